// File: rtl/fp_pkg.sv
// Shared constants and FSM encoding for the sequential
// single-precision adder.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;

  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC00000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_e;

endpackage

// File: rtl/fp_lzc24.sv
// Leading-zero count of a 24-bit word.
// An all-zero input reports 24.
module fp_lzc24 (
  input  logic [23:0] in_i,
  output logic [4:0]  cnt_o
);

  // Highest set bit wins, since the scan runs upward.
  always_comb begin
    cnt_o = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (in_i[i]) cnt_o = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 single adder, truncating,
// denormals flushed, with valid/ready on both sides.
module fp_add_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        busy
);

  state_e state_q, state_d;

  logic [31:0]        a_q, b_q;
  logic [31:0]        spv_q, sum_q;
  logic               sl_q, sub_q;
  logic               spec_q, zero_q, ov_q;
  logic [EXP_W-1:0]   el_q, es_q;
  logic [23:0]        ml_q, ms_q;
  logic [24:0]        r_q;
  logic [MANT_W-1:0]  mn_q;
  logic signed [9:0]  en_q;
  logic [4:0]         lz;

  logic [EXP_W-1:0]   ea, eb, sh;
  logic [23:0]        ma, mb;
  logic               a_nan, b_nan;
  logic               a_inf, b_inf;
  logic               a_big, spec_d;
  logic [31:0]        spv_d, pack_d;

  fp_lzc24 u_lzc (
    .in_i  (r_q[23:0]),
    .cnt_o (lz)
  );

  // Field split, hidden bit, special detection.
  always_comb begin
    ea    = a_q[30:23];
    eb    = b_q[30:23];
    ma    = (ea == '0) ? '0 : {1'b1, a_q[22:0]};
    mb    = (eb == '0) ? '0 : {1'b1, b_q[22:0]};
    a_nan = (ea == EXP_MAX) && (a_q[22:0] != '0);
    b_nan = (eb == EXP_MAX) && (b_q[22:0] != '0);
    a_inf = (ea == EXP_MAX) && (a_q[22:0] == '0);
    b_inf = (eb == EXP_MAX) && (b_q[22:0] == '0);
    a_big = {ea, ma} >= {eb, mb};
    spec_d = a_nan | b_nan | a_inf | b_inf;
    spv_d  = {b_q[31], EXP_MAX, {MANT_W{1'b0}}};
    if (a_nan || b_nan ||
        (a_inf && b_inf && (a_q[31] ^ b_q[31])))
      spv_d = QNAN;
    else if (a_inf)
      spv_d = {a_q[31], EXP_MAX, {MANT_W{1'b0}}};
    sh = el_q - es_q;
  end

  // Final packing: specials, zero, underflow, overflow.
  always_comb begin
    pack_d = {sl_q, en_q[7:0], mn_q};
    if (spec_q)
      pack_d = spv_q;
    else if (zero_q)
      pack_d = '0;
    else if (en_q <= 10'sd0)
      pack_d = {sl_q, 31'b0};
    else if (en_q >= 10'sd255)
      pack_d = {sl_q, EXP_MAX, {MANT_W{1'b0}}};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = ov_q;
    sum       = sum_q;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = S_UNPACK;
      end
      S_UNPACK: state_d = S_ALIGN;
      S_ALIGN:  state_d = S_ADD;
      S_ADD:    state_d = S_NORM;
      S_NORM:   state_d = S_DONE;
      S_DONE: begin
        if (ov_q && out_ready) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: one step of the add per state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      spv_q  <= '0;
      sum_q  <= '0;
      sl_q   <= 1'b0;
      sub_q  <= 1'b0;
      spec_q <= 1'b0;
      zero_q <= 1'b0;
      ov_q   <= 1'b0;
      el_q   <= '0;
      es_q   <= '0;
      ml_q   <= '0;
      ms_q   <= '0;
      r_q    <= '0;
      mn_q   <= '0;
      en_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
          end
        end
        S_UNPACK: begin
          sl_q   <= a_big ? a_q[31] : b_q[31];
          sub_q  <= a_q[31] ^ b_q[31];
          el_q   <= a_big ? ea : eb;
          es_q   <= a_big ? eb : ea;
          ml_q   <= a_big ? ma : mb;
          ms_q   <= a_big ? mb : ma;
          spec_q <= spec_d;
          spv_q  <= spv_d;
        end
        S_ALIGN: begin
          ms_q <= (sh > 8'd24) ? '0 : ms_q >> sh;
        end
        S_ADD: begin
          r_q <= sub_q ? {1'b0, ml_q} - {1'b0, ms_q}
                       : {1'b0, ml_q} + {1'b0, ms_q};
        end
        S_NORM: begin
          zero_q <= (r_q == '0);
          if (r_q[24]) begin
            mn_q <= r_q[23:1];
            en_q <= $signed({2'b00, el_q}) + 10'sd1;
          end else begin
            mn_q <= 23'(r_q[23:0] << lz);
            en_q <= $signed({2'b00, el_q})
                  - $signed({5'b00000, lz});
          end
        end
        S_DONE: begin
          if (!ov_q) begin
            sum_q <= pack_d;
            ov_q  <= 1'b1;
          end else if (out_ready) begin
            ov_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_seq.sv
// Scoreboard bench for fp_add_seq: directed corner
// cases plus random operands against a value model.
module tb_fp_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic        out_valid, out_ready;
  logic        busy;
  logic [31:0] a, b, sum;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          hs_edge = 0;
  int          last_acc = 0;
  bit          seen = 0;
  bit          rdy_rand = 0;
  logic [31:0] exp_q[$];
  int          acc_q[$];

  fp_add_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout want event", nm);
  endtask

  // Reference: exact integer significands, aligned with
  // discard, summed, then normalised by value.
  function automatic logic [31:0] ref_add(
      input logic [31:0] x, input logic [31:0] y);
    int     ex, ey, el, es, e;
    longint mx, my, ml, ms, r;
    bit     sx, sy, sl, ss, nx, ny, ix, iy;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    sx = x[31];
    sy = y[31];
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    if (nx || ny || (ix && iy && sx != sy))
      return 32'h7FC00000;
    if (ix) return {sx, 8'hFF, 23'b0};
    if (iy) return {sy, 8'hFF, 23'b0};
    mx = (ex == 0) ? 0 : longint'({1'b1, x[22:0]});
    my = (ey == 0) ? 0 : longint'({1'b1, y[22:0]});
    if (ex > ey || (ex == ey && mx >= my)) begin
      el = ex; es = ey; ml = mx; ms = my; sl = sx; ss = sy;
    end else begin
      el = ey; es = ex; ml = my; ms = mx; sl = sy; ss = sx;
    end
    ms = (el - es >= 40) ? 0 : (ms >> (el - es));
    r = (sl == ss) ? ml + ms : ml - ms;
    if (r == 0) return 32'h0;
    e = el;
    while (r >= (longint'(1) << 24)) begin
      r = r >> 1;
      e++;
    end
    while (r < (longint'(1) << 23)) begin
      r = r << 1;
      e--;
    end
    if (e <= 0) return {sl, 31'b0};
    if (e >= 255) return {sl, 8'hFF, 23'b0};
    return {sl, 8'(e), 23'(r)};
  endfunction

  function automatic logic [31:0] rnd_op(input int base);
    logic [31:0] r;
    int e;
    r = $urandom;
    case ($urandom_range(0, 15))
      0: r = {r[31], 31'b0};
      1: r = {r[31], 8'hFF, 23'b0};
      2: r = {r[31], 8'hFF, r[22:0] | 23'h1};
      3: r = {r[31], 8'h00, r[22:0]};
      4, 5: ;
      default: begin
        e = base + int'($urandom_range(0, 52)) - 26;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        r[30:23] = 8'(e);
      end
    endcase
    return r;
  endfunction

  task automatic send(input logic [31:0] x,
                      input logic [31:0] y,
                      input logic [31:0] e);
    int n;
    n = 0;
    @(negedge clk);
    a = x;
    b = y;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      flag("accept_timeout");
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(e);
      acc_q.push_back(cyc + 1);
      last_acc = cyc + 1;
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) flag("drain_timeout");
  endtask

  // Monitor: compares whatever the DUT presents.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      chk("busy_vs_ready", 32'(busy), 32'(!in_ready));
      if (out_valid) begin
        chk("ready_in_done", 32'(in_ready), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid: got %h want none",
                   sum);
        end else begin
          chk("sum", sum, exp_q[0]);
          if (!seen) begin
            chk("latency", 32'(cyc - acc_q[0]), 32'd5);
            seen = 1;
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            hs_edge = cyc + 1;
            seen = 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    flag("watchdog");
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  logic [31:0] da[10];
  logic [31:0] db[10];
  logic [31:0] ds[10];

  initial begin
    int n;
    da = '{32'h3F800000, 32'h40A00000, 32'h40400000,
           32'h7F7FFFFF, 32'h3F800000, 32'h7F800000,
           32'h7F800000, 32'h00000001, 32'h00000000,
           32'h80000000};
    db = '{32'h40000000, 32'hC0A00000, 32'hBF800000,
           32'h7F7FFFFF, 32'h33800000, 32'hFF800000,
           32'h3F800000, 32'h3F800000, 32'h80000000,
           32'hBF800000};
    ds = '{32'h40400000, 32'h00000000, 32'h40000000,
           32'h7F800000, 32'h3F800000, 32'h7FC00000,
           32'h7F800000, 32'h3F800000, 32'h00000000,
           32'hBF800000};

    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sum", sum, 32'h0);

    // Operands already waiting as reset lifts.
    a = da[0];
    b = db[0];
    in_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(ds[0]);
    acc_q.push_back(cyc + 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("first_accept_busy", 32'(busy), 32'd1);
    drain();

    for (int i = 1; i < 10; i++) begin
      send(da[i], db[i], ds[i]);
      chk("model_directed", ref_add(da[i], db[i]), ds[i]);
    end
    drain();

    // Consumer stalls in DONE while a second op waits.
    out_ready = 1'b0;
    send(32'h40400000, 32'hBF800000, 32'h40000000);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) flag("valid_timeout");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2 chk("hold_valid", 32'(out_valid), 32'd1);
    end
    fork
      send(32'h3F800000, 32'h40000000, 32'h40400000);
      begin
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    chk("accept_after_hs", 32'(last_acc > hs_edge), 32'd1);
    drain();

    // Reset while the op sits in ALIGN.
    send(32'h40A00000, 32'h3F800000, 32'h40C00000);
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    seen = 0;
    #2;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sum", sum, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (8) @(negedge clk);
    send(32'h40A00000, 32'h3F800000, 32'h40C00000);
    drain();

    // Random traffic with random back-pressure.
    rdy_rand = 1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] x, y;
      int base, k;
      k = int'($urandom_range(0, 3));
      if (k == 0)      base = int'($urandom_range(1, 6));
      else if (k == 1) base = int'($urandom_range(248, 254));
      else             base = int'($urandom_range(1, 254));
      x = rnd_op(base);
      if ($urandom_range(0, 9) == 0) y = x ^ 32'h80000000;
      else                           y = rnd_op(base);
      send(x, y, ref_add(x, y));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    rdy_rand = 0;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
